// File: rtl/mul_operand_sequencer.sv
// Register-mapped operand sequencer: streams N stored (A[i], B[i]) pairs into an external
// multiplier and captures each product into RES[i]. Optional WAIT timeout: SEQ_TIMEOUT_EN.
module mul_operand_sequencer #(
  parameter int W       = 12,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bus_wr,
  input  logic [7:0]   bus_addr,
  input  logic [15:0]  bus_wdata,
  output logic [15:0]  bus_rdata,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic         mul_start,
  input  logic         mul_done,
  input  logic [W-1:0] mul_p,
  output logic         trig
);

  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_N = 5'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end
  if (W < 1 || W > 16 || TIMEOUT < 1) begin : g_bad_width
    $error("W must be 1..16 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_mem   [DEPTH];
  logic [W-1:0]   b_mem   [DEPTH];
  logic [W-1:0]   res_mem [DEPTH];
  logic [IW-1:0]  index, index_inc, slot;
  logic [4:0]     n_reg;
  logic           done, timeout_err;
  logic           busy, go, n_ok, last, capture, expire, advance, slot_ok;
  logic [15:0]    rdata_next;
  logic           unused_wdata;

  assign busy      = (state == ISSUE) || (state == WAIT);
  assign mul_start = (state == ISSUE);
  assign go        = bus_wr && (state == IDLE) && (bus_addr == 8'h00) && bus_wdata[0];
  assign n_ok      = (n_reg != 5'd0) && (n_reg <= DEPTH_N);
  assign last      = (5'(index) == n_reg - 5'd1);
  assign capture   = (state == WAIT) && mul_done;
  assign advance   = capture || expire;
  assign index_inc = index + IW'(1);
  assign slot      = bus_addr[IW-1:0];
  assign slot_ok   = ({1'b0, bus_addr[3:0]} < DEPTH_N);

  // Upper write-data bits are only meaningful for some registers.
  assign unused_wdata = ^bus_wdata;

`ifdef SEQ_TIMEOUT_EN
  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt;

  // A product arriving on the final allowed cycle still wins over the timeout.
  assign expire = (state == WAIT) && !mul_done && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + CW'(1);
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go && n_ok) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (advance) state_next = last ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: defaulting rdata_next first means no decode path leaves it unassigned (no latch).
    rdata_next = '0;
    case (bus_addr[7:4])
      4'h0: begin
        if (bus_addr[3:0] == 4'h1) rdata_next = {11'd0, n_reg};
        if (bus_addr[3:0] == 4'h2) rdata_next = {4'd0, 4'(index), 5'd0, timeout_err, done, busy};
      end
      4'h1:    if (slot_ok) rdata_next = 16'(a_mem[slot]);
      4'h3:    if (slot_ok) rdata_next = 16'(b_mem[slot]);
      4'h5:    if (slot_ok) rdata_next = 16'(res_mem[slot]);
      default: ;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      index       <= '0;
      n_reg       <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      trig        <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      bus_rdata   <= '0;
      // NOTE: the slot memories are cleared too so readback after reset is deterministic.
      for (int i = 0; i < DEPTH; i++) begin
        a_mem[i]   <= '0;
        b_mem[i]   <= '0;
        res_mem[i] <= '0;
      end
    end else begin
      state     <= state_next;
      bus_rdata <= rdata_next;

      if (bus_wr && !busy) begin
        if (bus_addr == 8'h01)                a_mem[slot] <= a_mem[slot];
        if (bus_addr == 8'h01)                n_reg       <= bus_wdata[4:0];
        if (bus_addr[7:4] == 4'h1 && slot_ok) a_mem[slot] <= bus_wdata[W-1:0];
        if (bus_addr[7:4] == 4'h3 && slot_ok) b_mem[slot] <= bus_wdata[W-1:0];
      end

      if (go) begin
        timeout_err <= 1'b0;
        if (n_ok) begin
          index <= '0;
          done  <= 1'b0;
          trig  <= 1'b1;
          mul_a <= a_mem[0];
          mul_b <= b_mem[0];
        end else begin
          done  <= 1'b1;
        end
      end

      // Operands for the next pair are loaded on the capture edge so they are valid in ISSUE.
      if (advance) begin
        res_mem[index] <= capture ? mul_p : '1;
        if (expire) timeout_err <= 1'b1;
        if (last) begin
          done <= 1'b1;
          trig <= 1'b0;
        end else begin
          index <= index_inc;
          mul_a <= a_mem[index_inc];
          mul_b <= b_mem[index_inc];
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Self-checking bench for mul_operand_sequencer: register-map vector table plus directed
// multi-cycle sequences against a latency-4 "a*b mod 3329" multiplier model.
module tb_mul_operand_sequencer;

  localparam int W = 12, DEPTH = 8, TIMEOUT = 16, LAT = 4, NV = 23;

  logic         clk = 1'b0;
  logic         rst, bus_wr;
  logic [7:0]   bus_addr;
  logic [15:0]  bus_wdata, bus_rdata;
  logic [W-1:0] mul_a, mul_b, mul_p, model_p, inj_p;
  logic         mul_start, mul_done, model_done, inj_done, trig;

  int n_checks = 0, n_fail = 0;
  int start_total, stab_err, trig_cycles, trig_err;
  int withhold_at = -1;

  assign mul_done = model_done | inj_done;
  assign mul_p    = inj_done ? inj_p : model_p;

  always #5 clk = ~clk;

  mul_operand_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_done(mul_done), .mul_p(mul_p), .trig(trig)
  );

  // Multiplier model: product mod 3329, result pulse LAT cycles after the start cycle.
  initial begin : model
    int cnt;
    logic pend;
    logic [W-1:0] pa, pb;
    model_done = 1'b0; model_p = '0; start_total = 0; stab_err = 0;
    pend = 1'b0; cnt = 0; pa = '0; pb = '0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (rst) pend = 1'b0;
      else if (mul_start) begin
        start_total++;
        pa = mul_a; pb = mul_b; cnt = LAT - 1; pend = 1'b1;
      end else if (pend) begin
        if (mul_a !== pa || mul_b !== pb) stab_err++;
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          if (start_total != withhold_at) begin
            model_done = 1'b1;
            model_p    = W'((int'(pa) * int'(pb)) % 3329);
          end
        end
      end
    end
  end

  initial begin : trig_monitor
    trig_cycles = 0; trig_err = 0;
    forever begin
      @(negedge clk);
      if (trig === 1'b1) trig_cycles++;
      if (mul_start === 1'b1 && trig !== 1'b1) trig_err++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
    @(negedge clk);
    bus_wr = 1'b0; bus_addr = a;
    @(negedge clk);
    d = bus_rdata;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(name, 32'(d), 32'(exp));
  endtask

  task automatic wait_done(input string name, input int budget);
    logic [15:0] s;
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(8'h02, s);
      if (s[1]) ok = 1'b1;
    end
    check({name, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_starts(input string name, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (start_total >= target) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [15:0] d,
                              input logic [15:0] e);
    mk = '{wr: wr, addr: a, data: d, exp: e};
  endfunction

  initial begin : main
    vec_t        vecs [NV];
    int          av [DEPTH] = '{5, 7, 3328, 100, 200, 300, 400, 4095};
    int          bv [DEPTH] = '{9, 11, 2, 3, 5, 7, 11, 4095};
    int          snap_s, snap_t;
    logic [15:0] rd;

    vecs[0]  = mk(1'b0, 8'h02, 16'h0000, 16'h0000);
    vecs[1]  = mk(1'b0, 8'h01, 16'h0000, 16'h0000);
    vecs[2]  = mk(1'b0, 8'h10, 16'h0000, 16'h0000);
    vecs[3]  = mk(1'b0, 8'h17, 16'h0000, 16'h0000);
    vecs[4]  = mk(1'b0, 8'h50, 16'h0000, 16'h0000);
    vecs[5]  = mk(1'b1, 8'h10, 16'hF005, 16'h0000);
    vecs[6]  = mk(1'b0, 8'h10, 16'h0000, 16'h0005);
    vecs[7]  = mk(1'b1, 8'h11, 16'h0007, 16'h0000);
    vecs[8]  = mk(1'b1, 8'h12, 16'h0D00, 16'h0000);
    vecs[9]  = mk(1'b1, 8'h30, 16'h0009, 16'h0000);
    vecs[10] = mk(1'b1, 8'h31, 16'h000B, 16'h0000);
    vecs[11] = mk(1'b1, 8'h32, 16'h0002, 16'h0000);
    vecs[12] = mk(1'b0, 8'h12, 16'h0000, 16'h0D00);
    vecs[13] = mk(1'b0, 8'h32, 16'h0000, 16'h0002);
    vecs[14] = mk(1'b1, 8'h18, 16'h0FFF, 16'h0000);
    vecs[15] = mk(1'b0, 8'h10, 16'h0000, 16'h0005);
    vecs[16] = mk(1'b0, 8'h18, 16'h0000, 16'h0000);
    vecs[17] = mk(1'b0, 8'h40, 16'h0000, 16'h0000);
    vecs[18] = mk(1'b0, 8'hFF, 16'h0000, 16'h0000);
    vecs[19] = mk(1'b1, 8'h01, 16'hFFE3, 16'h0000);
    vecs[20] = mk(1'b0, 8'h01, 16'h0000, 16'h0003);
    vecs[21] = mk(1'b1, 8'h50, 16'h0123, 16'h0000);
    vecs[22] = mk(1'b0, 8'h50, 16'h0000, 16'h0000);

    rst = 1'b1; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0; inj_done = 1'b0; inj_p = '0;
    repeat (3) @(negedge clk);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_rdata", 32'(bus_rdata), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), 32'(rd), 32'(vecs[i].exp));
      end
    end

    // Three-pair run.
    snap_s = start_total; snap_t = trig_cycles;
    bus_write(8'h00, 16'h0001);
    wait_done("run3", 200);
    check("run3_starts", 32'(start_total - snap_s), 32'd3);
    check("run3_trig_cycles", 32'(trig_cycles - snap_t), 32'(3 * LAT));
    check("run3_trig_vs_start", 32'(trig_err), 32'd0);
    check("run3_operand_stable", 32'(stab_err), 32'd0);
    read_check("run3_res0", 8'h50, 16'd45);
    read_check("run3_res1", 8'h51, 16'd77);
    read_check("run3_res2", 8'h52, 16'd3327);
    bus_read(8'h02, rd);
    check("run3_status", 32'(rd[2:0]), 32'h2);

    // Stray product pulse while idle.
    @(negedge clk); inj_p = 12'hABC; inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    read_check("idle_done_res0", 8'h50, 16'd45);
    read_check("idle_done_res1", 8'h51, 16'd77);
    read_check("idle_done_res2", 8'h52, 16'd3327);

    // N beyond DEPTH is rejected.
    bus_write(8'h01, 16'd9);
    snap_s = start_total;
    bus_write(8'h00, 16'h0001);
    repeat (10) @(negedge clk);
    check("n9_no_start", 32'(start_total - snap_s), 32'd0);
    bus_read(8'h02, rd);
    check("n9_status", 32'(rd[1:0]), 32'h2);

    // Full-depth run with writes attempted while busy.
    for (int i = 3; i < DEPTH; i++) begin
      bus_write(8'h10 + 8'(i), 16'(av[i]));
      bus_write(8'h30 + 8'(i), 16'(bv[i]));
    end
    bus_write(8'h01, 16'd8);
    snap_s = start_total;
    bus_write(8'h00, 16'h0001);
    bus_write(8'h10, 16'h0123);
    bus_write(8'h01, 16'd2);
    bus_write(8'h00, 16'h0001);
    bus_read(8'h02, rd);
    check("busy_status", 32'(rd[1:0]), 32'h1);
    wait_done("run8", 300);
    check("run8_starts", 32'(start_total - snap_s), 32'd8);
    check("run8_operand_stable", 32'(stab_err), 32'd0);
    read_check("run8_a0_kept", 8'h10, 16'd5);
    read_check("run8_count_kept", 8'h01, 16'd8);
    for (int i = 0; i < DEPTH; i++)
      read_check($sformatf("run8_res%0d", i), 8'h50 + 8'(i), 16'((av[i] * bv[i]) % 3329));

    // Product withheld for pair 1.
    bus_write(8'h01, 16'd3);
    snap_s = start_total;
    withhold_at = snap_s + 2;
    bus_write(8'h00, 16'h0001);
`ifdef SEQ_TIMEOUT_EN
    wait_done("tmo", 300);
    withhold_at = -1;
    check("tmo_starts", 32'(start_total - snap_s), 32'd3);
    read_check("tmo_res0", 8'h50, 16'd45);
    read_check("tmo_res1", 8'h51, 16'h0FFF);
    read_check("tmo_res2", 8'h52, 16'd3327);
    bus_read(8'h02, rd);
    check("tmo_err_set", 32'(rd[2]), 32'd1);
    bus_write(8'h00, 16'h0001);
    wait_done("tmo_clear", 200);
    bus_read(8'h02, rd);
    check("tmo_err_cleared", 32'(rd[2]), 32'd0);
    read_check("tmo_clear_res1", 8'h51, 16'd77);
`else
    wait_starts("hold_pair1_started", snap_s + 2);
    repeat (40) @(negedge clk);
    bus_read(8'h02, rd);
    check("hold_status", 32'(rd & 16'h0F07), 32'h0101);
    @(negedge clk); inj_p = 12'h04D; inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    withhold_at = -1;
    wait_done("hold", 200);
    check("hold_starts", 32'(start_total - snap_s), 32'd3);
    read_check("hold_res1", 8'h51, 16'h004D);
    read_check("hold_res2", 8'h52, 16'd3327);
`endif

    // Reset while waiting on pair 2.
    snap_s = start_total;
    bus_write(8'h00, 16'h0001);
    wait_starts("rst_run_pair2", snap_s + 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_mul_start", 32'(mul_start), 32'd0);
    check("midrst_trig", 32'(trig), 32'd0);
    check("midrst_mul_a", 32'(mul_a), 32'd0);
    check("midrst_mul_b", 32'(mul_b), 32'd0);
    check("midrst_rdata", 32'(bus_rdata), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_start", 32'(start_total - snap_s), 32'd3);
    read_check("midrst_status", 8'h02, 16'h0000);
    read_check("midrst_count", 8'h01, 16'h0000);
    read_check("midrst_res0", 8'h50, 16'h0000);
    read_check("midrst_a2", 8'h12, 16'h0000);

    // N = 0 after reset.
    snap_s = start_total; snap_t = trig_cycles;
    bus_write(8'h00, 16'h0001);
    read_check("n0_status", 8'h02, 16'h0002);
    repeat (10) @(negedge clk);
    check("n0_no_start", 32'(start_total - snap_s), 32'd0);
    check("n0_no_trig", 32'(trig_cycles - snap_t), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_operand_sequencer.md
MUL_OPERAND_SEQUENCER -- requirements
Module: mul_operand_sequencer

Interface
REQ-001 SHALL have parameter W, default 12, operand/product width.
REQ-002 SHALL have parameter DEPTH, default 8, number of operand-pair slots (power of two, 2..16).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles per pair (used only with SEQ_TIMEOUT_EN).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port bus_wr  in  1  one-cycle write strobe.
REQ-007 SHALL have port bus_addr  in  8  register address.
REQ-008 SHALL have port bus_wdata  in  16  write data.
REQ-009 SHALL have port bus_rdata  out  16  registered read data for bus_addr, 1-cycle latency.
REQ-010 SHALL have port mul_a  out  W  operand a to multiplier array.
REQ-011 SHALL have port mul_b  out  W  operand b to multiplier array.
REQ-012 SHALL have port mul_start  out  1  one-cycle start pulse.
REQ-013 SHALL have port mul_done  in  1  multiplier result-valid pulse.
REQ-014 SHALL have port mul_p  in  W  multiplier product, valid with mul_done.
REQ-015 SHALL have port trig  out  1  scope trigger, high from first mul_start to last result capture.

Function
REQ-016 SHALL decode the register map: 0x00 CTRL (write bit0=1 -> go), 0x01 COUNT N (bits 4:0), 0x02 STATUS (bit0 busy, bit1 done, bit2 timeout_err, bits 11:8 current index), 0x10+i A[i], 0x30+i B[i], 0x50+i RES[i]; unmapped reads return 0x0000.
REQ-017 SHALL store only the low W bits of write data to A/B; reads zero-extend to 16 bits.
REQ-018 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
REQ-019 IDLE: go with 1<=N<=DEPTH -> ISSUE next cycle, index=0, done cleared; go with N=0 or N>DEPTH -> done=1 in the next cycle, no mul_start, remain IDLE.
REQ-020 ISSUE: SHALL drive mul_a=A[index], mul_b=B[index], assert mul_start for exactly one cycle, then enter WAIT.
REQ-021 mul_a/mul_b SHALL stay stable from ISSUE until the mul_done capture.
REQ-022 WAIT: on mul_done, SHALL write mul_p into RES[index] on that edge; if index==N-1 -> DONE, else index+1 and ISSUE next cycle.
REQ-023 DONE: SHALL set done=1, clear busy, return to IDLE after one cycle; done stays 1 until the next go or reset.
REQ-024 busy SHALL be 1 in ISSUE and WAIT only.
REQ-025 trig SHALL rise with the first mul_start and fall on the cycle after the final capture.
REQ-026 While busy: go, COUNT, and A/B writes SHALL be ignored; reads remain valid (RES holds partial results).
REQ-027 mul_done outside WAIT SHALL be ignored and SHALL NOT modify RES.
REQ-028 Minimum throughput: 2 cycles per pair plus multiplier latency.

Reset
REQ-029 rst SHALL force IDLE, index=0, busy=0, done=0, timeout_err=0, mul_start=0, trig=0, mul_a=mul_b=0, bus_rdata=0, N=0.
REQ-030 rst SHALL NOT be required to clear A, B, RES; implementation SHALL clear them to 0.
REQ-031 rst asserted mid-run SHALL abort on that edge; no further mul_start until a new go.

Configuration
REQ-032 With SEQ_TIMEOUT_EN defined: a WAIT counter SHALL abort after TIMEOUT cycles without mul_done, writing all-ones to RES[index], setting timeout_err=1, and continuing with the next pair; timeout_err clears on go.
REQ-033 Without SEQ_TIMEOUT_EN: no counter; WAIT holds indefinitely; STATUS bit2 reads 0.

Verification
REQ-034 Write A[0..2]=5,7,3328; B[0..2]=9,11,2; N=3; go; model returns a*b mod 3329 after 4 cycles -> RES=45,77,3327; done=1; exactly 3 mul_start pulses.
REQ-035 N=0, go -> done=1 next cycle, no mul_start, trig stays 0.
REQ-036 During a run with N=8, write A[0]=0x123 and N=2 -> ignored; readback after done shows the original A[0] and N=8.
REQ-037 Assert rst in WAIT of pair 2 -> all outputs at reset values next cycle; no mul_start until a new go.
REQ-038 (SEQ_TIMEOUT_EN, TIMEOUT=16) model withholds mul_done for pair 1 -> RES[1]=0xFFF, timeout_err=1, pair 2 still issued, done=1.
REQ-039 Inject mul_done in IDLE with mul_p=0xABC -> RES unchanged.
